id_ex_stage: RTL and testbench

ID/EX pipeline stage of the 8-bit pipelined RISC core. It registers decoded instruction fields from the decode stage and resolves operand forwarding from the EX/MEM and MEM/WB stages. It drives the operand, opcode and control inputs of the ALU directly. It also detects load-use hazards, inserts bubbles, supports hold and flush, and counts inserted bubbles.

---
 rtl/id_ex_stage_pkg.sv | 24 ++
 rtl/id_ex_stage_fwd_mux.sv | 50 +++++
 rtl/id_ex_stage.sv | 164 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | id_ex_stage_pkg: shared widths, ALU opcodes, forward selects      |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
package id_ex_stage_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_RA_W   = 3;
  localparam int DEF_OP_W   = 2;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_fwd_mux.sv
`default_nettype none
// +------------------------------------------------------------------+
// | id_ex_stage_fwd_mux: per-operand EX/MEM > MEM/WB > regfile select |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
module id_ex_stage_fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RA_W   = DEF_RA_W
) (
  input  logic [RA_W-1:0]   i_rs,
  input  logic [DATA_W-1:0] i_reg_data,
  input  logic              i_exmem_valid,
  input  logic              i_exmem_reg_write,
  input  logic [RA_W-1:0]   i_exmem_rd,
  input  logic [DATA_W-1:0] i_exmem_result,
  input  logic              i_memwb_valid,
  input  logic              i_memwb_reg_write,
  input  logic [RA_W-1:0]   i_memwb_rd,
  input  logic [DATA_W-1:0] i_memwb_data,
  output logic [DATA_W-1:0] o_data,
  output fwd_sel_t          o_sel
);

  logic w_exmem_hit;
  logic w_memwb_hit;

  assign w_exmem_hit = i_exmem_valid && i_exmem_reg_write &&
                       (i_exmem_rd != '0) && (i_exmem_rd == i_rs);
  assign w_memwb_hit = i_memwb_valid && i_memwb_reg_write &&
                       (i_memwb_rd != '0) && (i_memwb_rd == i_rs);

  // r0 is hardwired to zero no matter what the register file returned
  always_comb begin
    o_sel  = FWD_REG;
    o_data = i_reg_data;
    if (i_rs == '0) begin
      o_data = '0;
    end else if (w_exmem_hit) begin
      o_sel  = FWD_EXMEM;
      o_data = i_exmem_result;
    end else if (w_memwb_hit) begin
      o_sel  = FWD_MEMWB;
      o_data = i_memwb_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | id_ex_stage: ID/EX register with forwarding and load-use bubbles  |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RA_W   = DEF_RA_W,
  parameter int OP_W   = DEF_OP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [RA_W-1:0]   id_rs1,
  input  logic [RA_W-1:0]   id_rs2,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic [OP_W-1:0]   id_alu_op,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              exmem_valid,
  input  logic              exmem_reg_write,
  input  logic [RA_W-1:0]   exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_valid,
  input  logic              memwb_reg_write,
  input  logic [RA_W-1:0]   memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [OP_W-1:0]   ex_alu_op,
  output logic [RA_W-1:0]   ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              load_use_hazard,
  output logic [7:0]        bubble_count
);

  logic              r_valid;
  logic [RA_W-1:0]   r_rs1;
  logic [RA_W-1:0]   r_rs2;
  logic [RA_W-1:0]   r_rd;
  logic [DATA_W-1:0] r_rs1_data;
  logic [DATA_W-1:0] r_rs2_data;
  logic [DATA_W-1:0] r_imm;
  logic              r_use_imm;
  logic [OP_W-1:0]   r_alu_op;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [7:0]        r_bubble_count;

  logic [DATA_W-1:0] w_fwd_rs1;
  logic [DATA_W-1:0] w_fwd_rs2;
  fwd_sel_t          w_sel_rs1;
  fwd_sel_t          w_sel_rs2;
  logic              w_hazard;

  id_ex_stage_fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rs1 (
    .i_rs              (r_rs1),
    .i_reg_data        (r_rs1_data),
    .i_exmem_valid     (exmem_valid),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_result    (exmem_result),
    .i_memwb_valid     (memwb_valid),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_data      (memwb_data),
    .o_data            (w_fwd_rs1),
    .o_sel             (w_sel_rs1)
  );

  id_ex_stage_fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rs2 (
    .i_rs              (r_rs2),
    .i_reg_data        (r_rs2_data),
    .i_exmem_valid     (exmem_valid),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_result    (exmem_result),
    .i_memwb_valid     (memwb_valid),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_data      (memwb_data),
    .o_data            (w_fwd_rs2),
    .o_sel             (w_sel_rs2)
  );

  // rs2 only matters when it feeds the ALU or supplies store data
  assign w_hazard = r_valid && r_mem_read && id_valid && (r_rd != '0) &&
                    ((r_rd == id_rs1) ||
                     ((r_rd == id_rs2) && (!id_use_imm || id_mem_write)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid        <= 1'b0;
      r_rs1          <= '0;
      r_rs2          <= '0;
      r_rd           <= '0;
      r_rs1_data     <= '0;
      r_rs2_data     <= '0;
      r_imm          <= '0;
      r_use_imm      <= 1'b0;
      r_alu_op       <= ALU_ADD;
      r_reg_write    <= 1'b0;
      r_mem_read     <= 1'b0;
      r_mem_write    <= 1'b0;
      r_bubble_count <= '0;
    end else if (flush) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (stall) begin
      // Latch forwarded values so a producer retiring during the hold is kept
      if (w_sel_rs1 != FWD_REG) r_rs1_data <= w_fwd_rs1;
      if (w_sel_rs2 != FWD_REG) r_rs2_data <= w_fwd_rs2;
    end else if (w_hazard) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      if (r_bubble_count != 8'hFF) r_bubble_count <= r_bubble_count + 8'd1;
    end else begin
      r_valid     <= id_valid;
      r_rs1       <= id_rs1;
      r_rs2       <= id_rs2;
      r_rd        <= id_rd;
      r_rs1_data  <= id_rs1_data;
      r_rs2_data  <= id_rs2_data;
      r_imm       <= id_imm;
      r_use_imm   <= id_use_imm;
      r_alu_op    <= id_alu_op;
      r_reg_write <= id_reg_write;
      r_mem_read  <= id_mem_read;
      r_mem_write <= id_mem_write;
    end
  end

  assign ex_valid        = r_valid;
  assign ex_a            = w_fwd_rs1;
  assign ex_b            = r_use_imm ? r_imm : w_fwd_rs2;
  assign ex_store_data   = w_fwd_rs2;
  assign ex_alu_op       = r_alu_op;
  assign ex_rd           = r_rd;
  assign ex_reg_write    = r_valid && r_reg_write;
  assign ex_mem_read     = r_valid && r_mem_read;
  assign ex_mem_write    = r_valid && r_mem_write;
  assign load_use_hazard = w_hazard;
  assign bubble_count    = r_bubble_count;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_id_ex_stage: directed self-checking bench for id_ex_stage      |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
module tb_id_ex_stage;

  logic       clk = 1'b0;
  logic       reset, stall, flush;
  logic       id_valid;
  logic [2:0] id_rs1, id_rs2, id_rd;
  logic [7:0] id_rs1_data, id_rs2_data, id_imm;
  logic       id_use_imm;
  logic [1:0] id_alu_op;
  logic       id_reg_write, id_mem_read, id_mem_write;
  logic       exmem_valid, exmem_reg_write;
  logic [2:0] exmem_rd;
  logic [7:0] exmem_result;
  logic       memwb_valid, memwb_reg_write;
  logic [2:0] memwb_rd;
  logic [7:0] memwb_data;
  logic       ex_valid;
  logic [7:0] ex_a, ex_b, ex_store_data;
  logic [1:0] ex_alu_op;
  logic [2:0] ex_rd;
  logic       ex_reg_write, ex_mem_read, ex_mem_write;
  logic       load_use_hazard;
  logic [7:0] bubble_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_alu_op(id_alu_op),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exmem_valid(exmem_valid), .exmem_reg_write(exmem_reg_write),
    .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_valid(memwb_valid), .memwb_reg_write(memwb_reg_write),
    .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_alu_op(ex_alu_op),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data),
    .load_use_hazard(load_use_hazard), .bubble_count(bubble_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_use_imm = 1'b0;
    id_alu_op = 2'b00; id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
    exmem_valid = 1'b0; exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_valid = 1'b0; memwb_reg_write = 1'b0; memwb_rd = '0; memwb_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Present a load of r<rd> to be captured on the next edge
  task automatic present_load(input logic [2:0] rd);
    clear_inputs();
    id_valid = 1'b1; id_rd = rd; id_mem_read = 1'b1; id_reg_write = 1'b1;
  endtask

  task automatic present_dep_add(input logic [2:0] rs1);
    clear_inputs();
    id_valid = 1'b1; id_rs1 = rs1; id_rs2 = 3'd6; id_rd = 3'd7;
    id_reg_write = 1'b1; id_alu_op = 2'b00;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++; if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write} !== 4'b0)
      begin n_err++; $display("FAIL reset_ctrl got %b want 0000", {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write}); end
    n_cmp++; if ({ex_a, ex_b, ex_store_data} !== 24'h0)
      begin n_err++; $display("FAIL reset_data got %h want 000000", {ex_a, ex_b, ex_store_data}); end
    n_cmp++; if ({ex_alu_op, ex_rd, load_use_hazard} !== 6'b0)
      begin n_err++; $display("FAIL reset_misc got %b want 000000", {ex_alu_op, ex_rd, load_use_hazard}); end
    n_cmp++; if (bubble_count !== 8'd0)
      begin n_err++; $display("FAIL reset_bubbles got %0d want 0", bubble_count); end
    reset = 1'b0;
  endtask

  task automatic test_plain_issue();
    clear_inputs();
    id_valid = 1'b1; id_rs1 = 3'd2; id_rs1_data = 8'h10; id_rs2 = 3'd3; id_rs2_data = 8'h05;
    id_rd = 3'd4; id_alu_op = 2'b01; id_reg_write = 1'b1;
    tick();
    n_cmp++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL plain_valid got %b want 1", ex_valid); end
    n_cmp++; if (ex_a !== 8'h10) begin n_err++; $display("FAIL plain_a got %h want 10", ex_a); end
    n_cmp++; if (ex_b !== 8'h05) begin n_err++; $display("FAIL plain_b got %h want 05", ex_b); end
    n_cmp++; if (ex_alu_op !== 2'b01) begin n_err++; $display("FAIL plain_op got %b want 01", ex_alu_op); end
    n_cmp++; if ({ex_rd, ex_reg_write, ex_mem_read} !== {3'd4, 1'b1, 1'b0})
      begin n_err++; $display("FAIL plain_ctrl got %b want 10010", {ex_rd, ex_reg_write, ex_mem_read}); end
    // back-to-back immediate form: b takes imm, store data keeps rs2
    id_use_imm = 1'b1; id_imm = 8'h7F; id_alu_op = 2'b11;
    tick();
    n_cmp++; if (ex_b !== 8'h7F) begin n_err++; $display("FAIL imm_b got %h want 7f", ex_b); end
    n_cmp++; if (ex_store_data !== 8'h05) begin n_err++; $display("FAIL imm_store got %h want 05", ex_store_data); end
    n_cmp++; if (ex_alu_op !== 2'b11) begin n_err++; $display("FAIL imm_op got %b want 11", ex_alu_op); end
  endtask

  task automatic test_double_fwd();
    clear_inputs();
    id_valid = 1'b1; id_rs1 = 3'd4; id_rs1_data = 8'h11;
    tick();
    clear_inputs();
    exmem_valid = 1'b1; exmem_reg_write = 1'b1; exmem_rd = 3'd4; exmem_result = 8'hAA;
    memwb_valid = 1'b1; memwb_reg_write = 1'b1; memwb_rd = 3'd4; memwb_data = 8'h55;
    #1;
    n_cmp++; if (ex_a !== 8'hAA) begin n_err++; $display("FAIL fwd_exmem got %h want aa", ex_a); end
    exmem_valid = 1'b0;
    #1;
    n_cmp++; if (ex_a !== 8'h55) begin n_err++; $display("FAIL fwd_memwb got %h want 55", ex_a); end
    memwb_reg_write = 1'b0;
    #1;
    n_cmp++; if (ex_a !== 8'h11) begin n_err++; $display("FAIL fwd_none got %h want 11", ex_a); end
    clear_inputs();
    id_valid = 1'b1; id_rs1 = 3'd0; id_rs1_data = 8'h99;
    tick();
    exmem_valid = 1'b1; exmem_reg_write = 1'b1; exmem_rd = 3'd0; exmem_result = 8'hAA;
    memwb_valid = 1'b1; memwb_reg_write = 1'b1; memwb_rd = 3'd0; memwb_data = 8'h55;
    #1;
    n_cmp++; if (ex_a !== 8'h00) begin n_err++; $display("FAIL fwd_r0 got %h want 00", ex_a); end
  endtask

  task automatic test_load_use();
    do_reset();
    present_load(3'd1);
    tick();
    present_dep_add(3'd1);
    #1;
    n_cmp++; if (load_use_hazard !== 1'b1) begin n_err++; $display("FAIL lu_hazard got %b want 1", load_use_hazard); end
    tick();
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL lu_bubble got %b want 0", ex_valid); end
    n_cmp++; if (bubble_count !== 8'd1) begin n_err++; $display("FAIL lu_count got %0d want 1", bubble_count); end
    n_cmp++; if (load_use_hazard !== 1'b0) begin n_err++; $display("FAIL lu_clear got %b want 0", load_use_hazard); end
    // immediate operand that names the load target is not a dependency
    present_load(3'd1);
    tick();
    clear_inputs();
    id_valid = 1'b1; id_rs1 = 3'd2; id_rs2 = 3'd1; id_use_imm = 1'b1;
    #1;
    n_cmp++; if (load_use_hazard !== 1'b0) begin n_err++; $display("FAIL lu_imm got %b want 0", load_use_hazard); end
    id_mem_write = 1'b1;
    #1;
    n_cmp++; if (load_use_hazard !== 1'b1) begin n_err++; $display("FAIL lu_store got %b want 1", load_use_hazard); end
  endtask

  task automatic test_hold_refresh();
    do_reset();
    id_valid = 1'b1; id_rs2 = 3'd5; id_rs2_data = 8'h01; id_reg_write = 1'b1;
    tick();
    clear_inputs();
    stall = 1'b1;
    exmem_valid = 1'b1; exmem_reg_write = 1'b1; exmem_rd = 3'd5; exmem_result = 8'h3C;
    #1;
    n_cmp++; if (ex_b !== 8'h3C) begin n_err++; $display("FAIL hold_c1 got %h want 3c", ex_b); end
    tick();
    exmem_valid = 1'b0;
    #1;
    n_cmp++; if (ex_b !== 8'h3C) begin n_err++; $display("FAIL hold_c2 got %h want 3c", ex_b); end
    tick();
    n_cmp++; if (ex_b !== 8'h3C) begin n_err++; $display("FAIL hold_c3 got %h want 3c", ex_b); end
    n_cmp++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid got %b want 1", ex_valid); end
    tick();
    stall = 1'b0;
    #1;
    n_cmp++; if (ex_b !== 8'h3C) begin n_err++; $display("FAIL hold_release got %h want 3c", ex_b); end
  endtask

  task automatic test_flush_priority();
    do_reset();
    present_load(3'd1);
    tick();
    present_dep_add(3'd1);
    flush = 1'b1;
    tick();
    n_cmp++; if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write} !== 4'b0)
      begin n_err++; $display("FAIL flush_ctrl got %b want 0000", {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write}); end
    n_cmp++; if (bubble_count !== 8'd0) begin n_err++; $display("FAIL flush_count got %0d want 0", bubble_count); end
    present_load(3'd1);
    tick();
    present_dep_add(3'd1);
    stall = 1'b1;
    tick();
    n_cmp++; if ({ex_valid, ex_mem_read, ex_rd} !== {1'b1, 1'b1, 3'd1})
      begin n_err++; $display("FAIL stall_hold got %b want 11001", {ex_valid, ex_mem_read, ex_rd}); end
    n_cmp++; if (bubble_count !== 8'd0) begin n_err++; $display("FAIL stall_count got %0d want 0", bubble_count); end
    reset = 1'b1;
    tick();
    n_cmp++; if ({ex_valid, ex_mem_read, ex_reg_write, ex_rd, ex_a, ex_b, load_use_hazard, bubble_count} !== '0)
      begin n_err++; $display("FAIL reset_mid_stall got v=%b rd=%0d a=%h b=%h hz=%b bc=%0d want all 0",
                              ex_valid, ex_rd, ex_a, ex_b, load_use_hazard, bubble_count); end
    reset = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 260; i++) begin
      present_load(3'd1);
      tick();
      present_dep_add(3'd1);
      tick();
      if (i == 99) begin
        n_cmp++; if (bubble_count !== 8'd100)
          begin n_err++; $display("FAIL sat_mid got %0d want 100", bubble_count); end
      end
    end
    n_cmp++; if (bubble_count !== 8'd255) begin n_err++; $display("FAIL sat_final got %0d want 255", bubble_count); end
  endtask

  initial begin
    test_reset();
    test_plain_issue();
    test_double_fwd();
    test_load_use();
    test_hold_refresh();
    test_flush_priority();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
